data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-ported DataMemory (8-bit address, 8-bit data, ReadMem/WriteMem strobes).
- Requester 0 is the core load/store path; requester 1 is the debug/DMA loader.
- Each requester gets a req/gnt handshake and a read-return channel. The arbiter drives DataMemory's command inputs directly and captures DataOut after a configurable read latency.
- Only one memory operation is outstanding at any time.

Parameters:
- DATA_W, 8, data width; matches DataMemory DataIn/DataOut.
- ADDR_W, 8, address width; matches DataMemory data_addr.
- READ_LAT, 1, extra cycles after the ACCESS cycle before DataOut is sampled. Legal range 0..3; 0 means a combinational memory read.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request from requester 0 / 1; held until the matching gnt is seen.
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  ADDR_W  target address; stable while req is high.
- wdata0 / wdata1  in  DATA_W  write data; stable while req is high.
- gnt0 / gnt1  out  1  one-cycle pulse: the request has been accepted and is being issued this cycle.
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata holds the read result for that requester.
- rdata  out  DATA_W  read return data; shared by both ports, qualified by rvalid0/rvalid1.
- busy  out  1  high in any state other than IDLE.
- ReadMem  out  1  to DataMemory.
- WriteMem  out  1  to DataMemory.
- data_addr  out  ADDR_W  to DataMemory.
- DataIn  out  DATA_W  to DataMemory.
- DataOut  in  DATA_W  from DataMemory.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: gnt*, rvalid*, busy, ReadMem, WriteMem all 0; data_addr, DataIn and rdata all 0.
  - State: FSM goes to IDLE; last_grant=1, so port 0 wins the first contention.
  - WriteMem drops immediately on reset assertion. A write whose edge has not yet occurred is not performed. An in-flight read is dropped and produces no rvalid.
- Register outputs: all outputs are registered. DataMemory inputs change only on clk edges.
- FSM states: IDLE, ACCESS, WAIT, RETURN.
- IDLE:
  - Samples req0/req1. With none, stay in IDLE.
  - With one request, that port wins. With both, the port != last_grant wins.
  - On the edge, register the winner's addr into data_addr and wdata into DataIn. Set WriteMem=we or ReadMem=!we, pulse the winner's gnt, set owner and last_grant=winner, then go to ACCESS.
- ACCESS:
  - gnt is high for this cycle only.
  - Write: at the end of the cycle, WriteMem=0 and go to IDLE. DataMemory commits on this edge.
  - Read with READ_LAT=0: sample DataOut into rdata, ReadMem=0, go to RETURN.
  - Read with READ_LAT>0: load a counter with READ_LAT-1 and go to WAIT.
- WAIT:
  - ReadMem and data_addr are held.
  - When the counter reaches 0: sample DataOut into rdata, ReadMem=0, go to RETURN. Otherwise decrement.
- RETURN:
  - rvalid[owner]=1 for exactly this cycle; rdata is held until the next read capture.
  - Go to IDLE at the end of the cycle.
- Latency:
  - Write: gnt is at cycle t+1 after req is sampled at t; the next arbitration is at t+2.
  - Read: rvalid is at t+2+READ_LAT.
- Requester rule: deassert or change req in the cycle after gnt. A req still high when IDLE is re-entered is treated as a new request.
- Boundaries:
  - Both requests held continuously strictly alternate 0,1,0,1.
  - A request arriving during busy waits; there is no queueing beyond the held req.
  - Address 8'hFF and data 8'hFF pass through unmodified; there is no wrap logic.
  - A write and a read to the same address from different ports are ordered by grant order. A read granted after a write returns the new data.
  - gnt0 and gnt1 are never high together; rvalid0 and rvalid1 are never high together.

Test Plan:
- Reset, then req0 write addr 8'h00 data 8'h0F; later req0 read 8'h00 -> gnt0 one cycle after req; rvalid0 at t+3 (READ_LAT=1) with rdata=8'h0F.
- req0 write 8'h0C=8'h04 and req1 write 8'h0C=8'h06 in the same cycle from reset -> gnt0 first, then gnt1; a subsequent read of 8'h0C returns 8'h06 on the reader's rvalid only.
- req0 and req1 both held with reads of 8'h00 and 8'h0C -> grants alternate 0,1,0,1; rvalid0 always carries 8'h0F and rvalid1 8'h06; gnt and rvalid are never overlapped.
- Assert reset_n=0 during WAIT of a read and during ACCESS of a write to 8'h20 -> all outputs 0 immediately; no rvalid; a later read of 8'h20 shows the old value.
- READ_LAT=0 and READ_LAT=3 builds -> rvalid at t+2 and t+5 respectively; busy high from t+1 through RETURN.
- Write addr 8'hFF data 8'hFF, then read it back -> data_addr=8'hFF, rdata=8'hFF, no wrap.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-port sequencer in front of the single-ported DataMemory,
// one outstanding operation, read data captured READ_LAT cycles after the ACCESS cycle.
module data_mem_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ReadMem,
    output logic              WriteMem,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] DataIn,
    input  logic [DATA_W-1:0] DataOut
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RETURN = 2'd3;
    logic [1:0] state, cnt;
    logic owner, lastGrant, win, winWe, capture;
    assign win = req0 && req1 ? !lastGrant : req1;
    assign winWe = win ? we1 : we0;
    // DataOut is sampled on the edge that ends the last read-latency cycle
    assign capture = state == WAIT ? cnt == 2'd0 : state == ACCESS && ReadMem && READ_LAT == 0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= 2'd0;
            owner <= 1'b0;
            lastGrant <= 1'b1;
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata <= '0;
            busy <= 1'b0;
            ReadMem <= 1'b0;
            WriteMem <= 1'b0;
            data_addr <= '0;
            DataIn <= '0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            rvalid0 <= capture && !owner;
            rvalid1 <= capture && owner;
            if (capture) begin
                rdata <= DataOut;
                ReadMem <= 1'b0;
            end
            case (state)
                IDLE: if (req0 || req1) begin
                    data_addr <= win ? addr1 : addr0;
                    DataIn <= win ? wdata1 : wdata0;
                    WriteMem <= winWe;
                    ReadMem <= !winWe;
                    gnt0 <= !win;
                    gnt1 <= win;
                    owner <= win;
                    lastGrant <= win;
                    busy <= 1'b1;
                    state <= ACCESS;
                end
                ACCESS: if (WriteMem) begin
                    WriteMem <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end else if (capture) begin
                    state <= RETURN;
                end else begin
                    cnt <= 2'(READ_LAT - 1);
                    state <= WAIT;
                end
                WAIT: if (capture) state <= RETURN; else cnt <= cnt - 2'd1;
                RETURN: begin
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
